// File: rtl/response_streamer_pkg.sv
// ----------------------------------------------------------------------------
// response_streamer_pkg
// Shared processor package: default widths for the response path, the
// response streamer state encoding, and a few control-unit constants that
// live alongside it so the whole processor uses one source of truth.
// ----------------------------------------------------------------------------
package response_streamer_pkg;

    // Default widths of the response memory / output stream
    localparam int RS_ADDR_W = 8;
    localparam int RS_DATA_W = 8;

    // Control-unit constants
    localparam int          CU_PC_W     = 8;
    localparam int          CU_OPCODE_W = 4;
    localparam logic [3:0]  CU_OP_NOP   = 4'h0;
    localparam logic [3:0]  CU_OP_HALT  = 4'hF;

    // Response streamer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } rs_state_e;

endpackage : response_streamer_pkg

// File: rtl/response_streamer.sv
// ----------------------------------------------------------------------------
// response_streamer
// After program execution ends, reads resp_count words out of the external
// response memory and streams them on a valid/ready interface. Words at even
// addresses are tagged as instruction words (out_kind=0), odd addresses as
// result words (out_kind=1). One word is emitted every three cycles when the
// consumer is always ready.
//
// Ports
//   clock          : single clock, rising edge
//   reset          : asynchronous, active-low reset
//   file_finished  : high while program execution has ended; a rising edge
//                    while idle starts a stream
//   resp_count     : number of valid response words, sampled at start
//   mem_addr       : response-memory read address
//   mem_rd_en      : response-memory read strobe (one cycle per word)
//   mem_rdata      : response-memory read data, valid one cycle after strobe
//   out_data       : streamed word
//   out_kind       : 0 = instruction word, 1 = result word
//   out_last       : final word of the stream
//   out_valid      : out_data/out_kind/out_last are valid
//   out_ready      : consumer accepts the word on valid & ready
//   busy           : stream in progress
//   done           : stream complete, held until file_finished falls
// ----------------------------------------------------------------------------
module response_streamer
    import response_streamer_pkg::*;
#(
    parameter int ADDR_W = RS_ADDR_W,
    parameter int DATA_W = RS_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              file_finished,
    input  logic [ADDR_W-1:0] resp_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_kind,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    rs_state_e         r_state;
    rs_state_e         w_state_next;
    logic              r_ff_prev;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_kind;
    logic [DATA_W-1:0] r_data;

    logic              w_start;
    logic              w_handshake;
    logic              w_at_last;

    // Only a fresh rising edge of file_finished starts a stream. The edge
    // register comes out of reset at 1 so a level that is already high when
    // reset releases cannot trigger a new stream by itself.
    assign w_start     = (r_state == ST_IDLE) && file_finished && !r_ff_prev;
    assign w_handshake = (r_state == ST_SEND) && out_ready;
    assign w_at_last   = (r_addr == (r_count - ADDR_W'(1)));

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ff_prev <= 1'b1;
            r_count   <= '0;
            r_addr    <= '0;
            r_kind    <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ff_prev <= file_finished;

            if (w_start) begin
                r_count <= resp_count;
                r_addr  <= '0;
                r_kind  <= 1'b0;
            end

            // Memory data arrives the cycle after the read strobe
            if (r_state == ST_WAIT) begin
                r_data <= mem_rdata;
            end

            // Address and kind advance together, so kind always tracks the
            // address parity. The count is at most 2^ADDR_W-1, so the
            // increment after the last word never wraps.
            if (w_handshake) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_kind <= ~r_kind;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        mem_rd_en    = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    // An empty response goes straight to DONE with no beat
                    w_state_next = (resp_count == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                mem_rd_en    = 1'b1;
                busy         = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                busy         = 1'b1;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = w_at_last;
                if (out_ready) begin
                    w_state_next = w_at_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                // file_finished may have dropped mid-stream; leave at once then
                if (!file_finished) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_addr = r_addr;
    assign out_data = r_data;
    assign out_kind = r_kind;

endmodule : response_streamer

// File: tb/tb_response_streamer.sv
// ----------------------------------------------------------------------------
// tb_response_streamer
// Directed stimulus with a scoreboard: each test pushes the beats it expects
// into a queue, and an independent monitor pops and compares whenever a beat
// is accepted on the output interface.
// ----------------------------------------------------------------------------
module tb_response_streamer;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic              clock;
    logic              reset;
    logic              file_finished;
    logic [ADDR_W-1:0] resp_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_kind;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    response_streamer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .file_finished(file_finished),
        .resp_count   (resp_count),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata),
        .out_data     (out_data),
        .out_kind     (out_kind),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Response memory model: registered read, one cycle latency
    logic [DATA_W-1:0] mem [256];
    always @(posedge clock) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    int errors = 0;
    int checks = 0;
    int rd_count = 0;
    int beat_no = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              k;
        logic              l;
    } beat_t;
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [DATA_W-1:0] d, input logic k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done) break;
            tick(1);
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    // Read strobes counted once per cycle
    always @(negedge clock) begin
        if (mem_rd_en) rd_count++;
    end

    // Monitor: stability while stalled, and scoreboard compare on acceptance
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] held_data;
    logic              held_kind;
    logic              held_last;
    always @(negedge clock) begin
        beat_t b;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data",  {24'd0, out_data}, {24'd0, held_data});
                chk("stall_kind",  {31'd0, out_kind}, {31'd0, held_kind});
                chk("stall_last",  {31'd0, out_last}, {31'd0, held_last});
            end
            prev_stall = out_valid && !out_ready;
            held_data  = out_data;
            held_kind  = out_kind;
            held_last  = out_last;
            if (out_valid && out_ready) begin
                beat_no++;
                $display("beat %0d data=0x%02h kind=%0d last=%0d", beat_no, out_data, out_kind, out_last);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%02h expected no beat", out_data);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", {24'd0, out_data}, {24'd0, b.d});
                    chk("beat_kind", {31'd0, out_kind}, {31'd0, b.k});
                    chk("beat_last", {31'd0, out_last}, {31'd0, b.l});
                end
            end
        end
    end

    // Watchdog: the bench must always terminate
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int rd_base;

    initial begin
        reset         = 1'b0;
        file_finished = 1'b0;
        resp_count    = '0;
        out_ready     = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 8'h10; mem[1] = 8'h2A; mem[2] = 8'h03; mem[3] = 8'hF5;

        // ---- reset state ----
        tick(2);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_done",      {31'd0, done}, 32'd0);
        chk("rst_rd_en",     {31'd0, mem_rd_en}, 32'd0);
        chk("rst_addr",      {24'd0, mem_addr}, 32'd0);
        chk("rst_data",      {24'd0, out_data}, 32'd0);
        reset = 1'b1;
        tick(2);

        // ---- count=4, ready always high ----
        resp_count = 8'd4;
        push_beat(8'h10, 1'b0, 1'b0);
        push_beat(8'h2A, 1'b1, 1'b0);
        push_beat(8'h03, 1'b0, 1'b0);
        push_beat(8'hF5, 1'b1, 1'b1);
        rd_base = rd_count;
        file_finished = 1'b1;
        tick(1);
        chk("t1_read_busy",  {31'd0, busy}, 32'd1);
        chk("t1_read_rd_en", {31'd0, mem_rd_en}, 32'd1);
        chk("t1_read_addr",  {24'd0, mem_addr}, 32'd0);
        chk("t1_read_valid", {31'd0, out_valid}, 32'd0);
        tick(1);
        chk("t1_wait_valid", {31'd0, out_valid}, 32'd0);
        tick(1);
        chk("t1_first_valid", {31'd0, out_valid}, 32'd1);
        tick(9);
        chk("t1_last_flag",  {31'd0, out_last}, 32'd1);
        chk("t1_done_early", {31'd0, done}, 32'd0);
        tick(1);
        chk("t1_done",       {31'd0, done}, 32'd1);
        chk("t1_done_busy",  {31'd0, busy}, 32'd0);
        chk("t1_done_valid", {31'd0, out_valid}, 32'd0);
        tick(3);
        chk("t1_done_held",  {31'd0, done}, 32'd1);
        file_finished = 1'b0;
        tick(1);
        chk("t1_done_clear", {31'd0, done}, 32'd0);
        chk("t1_reads",      rd_count - rd_base, 32'd4);
        chk("t1_sb_empty",   exp_q.size(), 32'd0);

        // ---- count=0: no beat, done next cycle ----
        tick(1);
        resp_count = 8'd0;
        file_finished = 1'b1;
        tick(1);
        chk("t2_done",  {31'd0, done}, 32'd1);
        chk("t2_busy",  {31'd0, busy}, 32'd0);
        chk("t2_valid", {31'd0, out_valid}, 32'd0);
        tick(1);
        chk("t2_busy2", {31'd0, busy}, 32'd0);
        file_finished = 1'b0;
        tick(1);
        chk("t2_done_clear", {31'd0, done}, 32'd0);

        // ---- count=2 with a 5-cycle stall on the first beat ----
        tick(1);
        mem[0] = 8'hA5; mem[1] = 8'h3C;
        resp_count = 8'd2;
        push_beat(8'hA5, 1'b0, 1'b0);
        push_beat(8'h3C, 1'b1, 1'b1);
        rd_base = rd_count;
        out_ready = 1'b0;
        file_finished = 1'b1;
        tick(3);
        chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
        tick(5);
        chk("t3_stall_data", {24'd0, out_data}, 32'h0000_00A5);
        chk("t3_stall_kind", {31'd0, out_kind}, 32'd0);
        out_ready = 1'b1;
        wait_done("t3_done_timeout", 50);
        chk("t3_reads",    rd_count - rd_base, 32'd2);
        chk("t3_sb_empty", exp_q.size(), 32'd0);
        file_finished = 1'b0;
        tick(2);

        // ---- count=3: odd count ends on an instruction word ----
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        resp_count = 8'd3;
        push_beat(8'h11, 1'b0, 1'b0);
        push_beat(8'h22, 1'b1, 1'b0);
        push_beat(8'h33, 1'b0, 1'b1);
        file_finished = 1'b1;
        tick(1);
        wait_done("t4_done_timeout", 50);
        chk("t4_sb_empty", exp_q.size(), 32'd0);
        file_finished = 1'b0;
        tick(2);

        // ---- reset during the 2nd SEND of count=4, file_finished held ----
        mem[0] = 8'h10; mem[1] = 8'h2A; mem[2] = 8'h03; mem[3] = 8'hF5;
        resp_count = 8'd4;
        push_beat(8'h10, 1'b0, 1'b0);
        rd_base = rd_count;
        file_finished = 1'b1;
        tick(6);
        chk("t5_second_send", {31'd0, out_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_busy",  {31'd0, busy}, 32'd0);
        chk("t5_rst_addr",  {24'd0, mem_addr}, 32'd0);
        chk("t5_rst_data",  {24'd0, out_data}, 32'd0);
        chk("t5_rst_kind",  {31'd0, out_kind}, 32'd0);
        chk("t5_rst_done",  {31'd0, done}, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(6);
        chk("t5_no_restart_busy", {31'd0, busy}, 32'd0);
        chk("t5_no_restart_done", {31'd0, done}, 32'd0);
        chk("t5_reads",    rd_count - rd_base, 32'd2);
        chk("t5_sb_empty", exp_q.size(), 32'd0);
        file_finished = 1'b0;
        tick(1);
        push_beat(8'h10, 1'b0, 1'b0);
        push_beat(8'h2A, 1'b1, 1'b0);
        push_beat(8'h03, 1'b0, 1'b0);
        push_beat(8'hF5, 1'b1, 1'b1);
        file_finished = 1'b1;
        tick(1);
        wait_done("t5_restart_timeout", 50);
        chk("t5_restart_sb_empty", exp_q.size(), 32'd0);
        file_finished = 1'b0;
        tick(2);

        // ---- file_finished dropped after the first beat ----
        push_beat(8'h10, 1'b0, 1'b0);
        push_beat(8'h2A, 1'b1, 1'b0);
        push_beat(8'h03, 1'b0, 1'b0);
        push_beat(8'hF5, 1'b1, 1'b1);
        file_finished = 1'b1;
        tick(4);
        file_finished = 1'b0;
        wait_done("t6_done_timeout", 50);
        tick(1);
        chk("t6_done_pulse", {31'd0, done}, 32'd0);
        chk("t6_busy",       {31'd0, busy}, 32'd0);
        chk("t6_sb_empty",   exp_q.size(), 32'd0);
        tick(3);
        chk("t6_idle_busy",  {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_response_streamer
